mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 single-bit multiplexer between four requesters.
- Registers a one-hot grant and drives the mux select lines address1/address0 from the granted index.
- Presents the selected data bit downstream with a valid flag.
- Bounds each tenure with a beat limit so no requester can starve the others.
- Sits between four producer bit-streams and a single shared output wire.

Parameters:
MAX_BEATS, 4, maximum consecutive valid beats per grant; legal range 1..255.
CNT_W, 8, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  4  per-requester request; bit i belongs to requester i.
in0, in1, in2, in3  input  1 each  requester data bits, fed to the mux data inputs.
gnt  output  4  registered one-hot grant; 4'b0000 when nothing is granted.
address0, address1  output  1 each  registered mux select; {address1,address0} = granted index.
out  output  1  mux output, combinational from the registered select and in0..in3.
out_valid  output  1  high when a grant is active and the granted req bit is high.
busy  output  1  high while in the GRANT state.

Behaviour:
Interface (already decided):
- One clock, clk.
- reset is asynchronous and active-high.

Reset:
- Takes effect immediately with no clock edge: state=IDLE, gnt=0, address1/address0=0, ptr=0, beat count=0.
- Outputs then read out_valid=0, busy=0; out = in0.

Pointer and state:
- ptr is a 2-bit round-robin pointer naming the highest-priority requester.
- States: IDLE and GRANT.

IDLE:
- At each edge, if req != 0, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Register gnt=onehot(idx), {address1,address0}=idx, count=1; go to GRANT.
- If req = 0: stay in IDLE, gnt=0, address bits hold their last value (no select toggling while idle).

Grant latency:
- req sampled high at edge k gives gnt high after edge k (one registered stage).
- out is valid in the cycle following edge k.

GRANT:
- out_valid = req[idx]; out = in[idx].
- Release at an edge if req[idx] is sampled low, or if count == MAX_BEATS.
- Otherwise increment count.

On release:
- gnt=0, ptr=idx+1 mod 4 (wraps 3 to 0), state returns to IDLE.
- This guarantees exactly one dead cycle between any two grants, including a re-grant to the same requester.

Boundary conditions:
- Req bits of non-granted requesters are ignored during GRANT; they are neither latched nor lost, and are arbitrated after release.
- MAX_BEATS=1: every grant lasts exactly one cycle.
- A requester dropping req in the same cycle as it reaches the limit is one release, with one ptr advance.
- A single lone requester is re-granted after each dead cycle, regardless of ptr.
- Reset asserted mid-grant aborts the tenure immediately; no partial state survives.

Optional Feature:
Macro: MUX_RR_ARBITER_LOCK_EN
Defined:
- Adds input port lock (1 bit).
- While in GRANT with lock sampled high, the MAX_BEATS limit is suppressed and release occurs only when req[idx] drops.
- The count saturates at MAX_BEATS.
- lock is ignored in IDLE.
Undefined:
- No lock port.
- The beat limit always applies.

Test Plan:
1. Hold reset with req=4'b1111 -> gnt=0000, address1/0=0/0, out_valid=0; release reset, first edge -> gnt=0001.
2. MAX_BEATS=4, only req[2] held 12 cycles, in2 toggling -> gnt=0100 for 4 cycles, {address1,address0}=2'b10, out tracks in2, out_valid=1, then 1 cycle gnt=0000, then gnt=0100 again.
3. req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001; each 4 cycles long, separated by one idle cycle; ptr wraps 3 to 0.
4. Requester 1 granted, drops req after 2 valid beats, req[3] and req[0] pending -> release at next edge, ptr=2; next grant 1000 (requester 3 before 0).
5. Assert reset asynchronously mid-cycle while gnt=0100 -> gnt=0000, out_valid=0, busy=0 before the next clk edge; after reset, ptr=0.
6. Build with MUX_RR_ARBITER_LOCK_EN, MAX_BEATS=4; req[0] and lock held 10 cycles -> gnt=0001 for all 10 cycles; drop lock -> release at the next edge (count already saturated).

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one 4:1 single-bit multiplexer between
//   four requesters. A one-hot grant and the mux select lines are registered.
//   The selected data bit is presented downstream together with a valid flag.
//   Each tenure is bounded by MAX_BEATS cycles so no requester can starve the
//   others. Every release is followed by exactly one idle cycle.
//
// Optional feature (macro MUX_RR_ARBITER_LOCK_EN):
//   Adds a 'lock' input. While granted with lock high, the beat limit is
//   suppressed and the beat count saturates at MAX_BEATS.
//
// Parameters:
//   MAX_BEATS  maximum consecutive beats per grant (1..255)
//   CNT_W      beat counter width, 2^CNT_W > MAX_BEATS
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   req[3:0]            per-requester request lines
//   in0..in3            requester data bits (mux data inputs)
//   lock                (MUX_RR_ARBITER_LOCK_EN only) suppresses beat limit
//   gnt[3:0]            registered one-hot grant
//   address1/address0   registered mux select = granted index
//   out                 mux output selected by the registered address
//   out_valid           grant active and granted request high
//   busy                arbiter is in the GRANT state
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
   parameter int MAX_BEATS = 4,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   input  logic       in3,
`ifdef MUX_RR_ARBITER_LOCK_EN
   input  logic       lock,
`endif
   output logic [3:0] gnt,
   output logic       address0,
   output logic       address1,
   output logic       out,
   output logic       out_valid,
   output logic       busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_t           state_r;
   state_t           state_s;
   logic [1:0]       ptr_r;
   logic [1:0]       ptr_s;
   logic [1:0]       idx_r;
   logic [1:0]       idx_s;
   logic [3:0]       gnt_r;
   logic [3:0]       gnt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             at_limit_s;
   logic             release_s;
   logic             lock_s;

   // First set request bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] j;
      logic [1:0] sel;
      logic       found;
      sel   = p;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         j = p + 2'(k);
         if (!found && r[j]) begin
            sel   = j;
            found = 1'b1;
         end else begin
            sel   = sel;
         end
      end
      return sel;
   endfunction

   function automatic logic [3:0] to_onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

`ifdef MUX_RR_ARBITER_LOCK_EN
   assign lock_s = lock;
`else
   assign lock_s = 1'b0;
`endif

   // Next-state logic: arbitration in IDLE, tenure tracking and release in GRANT.
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      idx_s      = idx_r;
      gnt_s      = gnt_r;
      cnt_s      = cnt_r;
      at_limit_s = (cnt_r == MAX_CNT);
      release_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req != 4'b0000) begin
               idx_s   = rr_pick(req, ptr_r);
               gnt_s   = to_onehot(idx_s);
               cnt_s   = ONE_CNT;
               state_s = ST_GRANT;
            end else begin
               // Select lines hold so the mux does not toggle while idle.
               gnt_s   = 4'b0000;
            end
         end
         ST_GRANT: begin
            // A limit hit and a request drop in the same cycle are one release.
            release_s = !req[idx_r] || (at_limit_s && !lock_s);
            if (release_s) begin
               gnt_s   = 4'b0000;
               ptr_s   = idx_r + 2'd1;
               cnt_s   = {CNT_W{1'b0}};
               state_s = ST_IDLE;
            end else if (!at_limit_s) begin
               cnt_s   = cnt_r + ONE_CNT;
            end else begin
               // Locked past the limit: count saturates.
               cnt_s   = cnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = 4'b0000;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, pointer, select and grant registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         ptr_r   <= 2'd0;
         idx_r   <= 2'd0;
         gnt_r   <= 4'b0000;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         idx_r   <= idx_s;
         gnt_r   <= gnt_s;
         cnt_r   <= cnt_s;
      end
   end

   // Shared 4:1 mux driven by the registered select.
   always_comb begin
      out = in0;
      case (idx_r)
         2'd0:    out = in0;
         2'd1:    out = in1;
         2'd2:    out = in2;
         2'd3:    out = in3;
         default: out = in0;
      endcase
   end

   assign gnt       = gnt_r;
   assign address1  = idx_r[1];
   assign address0  = idx_r[0];
   assign busy      = (state_r == ST_GRANT);
   assign out_valid = (state_r == ST_GRANT) && req[idx_r];

endmodule
